// File: rtl/pass_keeper_pkg.sv
// ----------------------------------------------------------------------------
// pass_keeper_pkg
//   Shared definitions for the password-vault byte-stream front end:
//   FSM state encoding, command opcodes, acknowledge nibble, the default
//   per-slot byte count and a counter-width helper.
//   No ports (package).
// ----------------------------------------------------------------------------
package pass_keeper_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_DATA,
        WR,
        FETCH,
        TX_DATA,
        ACK
    } state_t;

    localparam logic [1:0] CMD_WRITE  = 2'b01;
    localparam logic [1:0] CMD_READ   = 2'b10;
    localparam logic [3:0] ACK_NIBBLE = 4'hA;

    // Byte count of a default 256-bit slot; the controller derives its own
    // count from its DATA_W parameter.
    localparam int DATA_W_DEFAULT = 256;
    localparam int NBYTES         = DATA_W_DEFAULT / 8;

    // Width of a counter that indexes nbytes bytes (at least one bit).
    function automatic int cnt_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/vault_stream_if.sv
// ----------------------------------------------------------------------------
// vault_stream_if
//   Bundles the inbound byte link, outbound byte link, vault RAM port and
//   status flags of the vault stream controller.
//   Parameters: DATA_W (slot width, bits), ADDR_W (slot address width).
//   Signals:
//     s_data/s_valid/s_ready  inbound bytes (host -> controller)
//     m_data/m_valid/m_ready  outbound bytes (controller -> host)
//     ram_addr/ram_wdata/ram_we/ram_rdata  vault RAM port (rdata combinational)
//     busy, err               status
//   Modports:
//     master  controller side (drives s_ready, m_*, ram_*, busy, err)
//     slave   environment side (host link and RAM)
// ----------------------------------------------------------------------------
interface vault_stream_if #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 4
);
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic [7:0]        m_data;
    logic              m_valid;
    logic              m_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic              busy;
    logic              err;

    modport master (
        input  s_data, s_valid, m_ready, ram_rdata,
        output s_ready, m_data, m_valid, ram_addr, ram_wdata, ram_we, busy, err
    );

    modport slave (
        output s_data, s_valid, m_ready, ram_rdata,
        input  s_ready, m_data, m_valid, ram_addr, ram_wdata, ram_we, busy, err
    );
endinterface

// File: rtl/vault_stream_ctrl.sv
// ----------------------------------------------------------------------------
// vault_stream_ctrl
//   Byte-stream front end for the 2**ADDR_W x DATA_W password vault RAM.
//   WRITE command (cmd[7:6]=01) plus DATA_W/8 payload bytes, LSB byte first,
//   becomes one RAM write to slot cmd[ADDR_W-1:0]. READ command
//   (cmd[7:6]=10) fetches that slot and streams it back LSB byte first.
//   Any other command byte is consumed and flagged with a one-cycle err.
//   Optional feature macro: VAULT_ACK_EN -- after each RAM write, send one
//   acknowledge byte {4'hA, slot} on the outbound link.
//   Ports:
//     clk   clock
//     rst   synchronous reset, active-high
//     bus   vault_stream_if.master (byte links, RAM port, busy, err)
// ----------------------------------------------------------------------------
module vault_stream_ctrl
    import pass_keeper_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    vault_stream_if.master bus
);

    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = cnt_width(NB);

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  slot;
    logic [DATA_W-1:0]  data_buf;
    logic               err_q;

    logic               s_ready;
    logic               m_valid;
    logic [7:0]         m_data;
    logic               accept;
    logic               tx_hs;
    logic               last_byte;
    logic               illegal;

    assign accept    = bus.s_valid && s_ready;
    assign tx_hs     = m_valid && bus.m_ready;
    assign last_byte = (cnt == CNT_W'(NB - 1));
    assign illegal   = (bus.s_data[7:6] != CMD_WRITE) && (bus.s_data[7:6] != CMD_READ);

    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        s_ready    = !rst && ((state == IDLE) || (state == RX_DATA));
        m_valid    = (state == TX_DATA);
        m_data     = data_buf[{cnt, 3'b000} +: 8];
`ifdef VAULT_ACK_EN
        if (state == ACK) begin
            m_valid = 1'b1;
            m_data  = {ACK_NIBBLE, 4'(slot)};
        end
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.s_data[7:6] == CMD_WRITE)     next_state = RX_DATA;
                    else if (bus.s_data[7:6] == CMD_READ) next_state = FETCH;
                end
            end
            RX_DATA: if (accept && last_byte) next_state = WR;
`ifdef VAULT_ACK_EN
            WR:      next_state = ACK;
            ACK:     if (bus.m_ready) next_state = IDLE;
`else
            WR:      next_state = IDLE;
`endif
            FETCH:   next_state = TX_DATA;
            TX_DATA: if (tx_hs && last_byte) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            slot     <= '0;
            data_buf <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= next_state;
            err_q <= (state == IDLE) && accept && illegal;
            case (state)
                IDLE: begin
                    if (accept && !illegal) begin
                        slot <= bus.s_data[ADDR_W-1:0];
                        cnt  <= '0;
                    end
                end
                RX_DATA: begin
                    if (accept) begin
                        data_buf[{cnt, 3'b000} +: 8] <= bus.s_data;
                        cnt <= last_byte ? '0 : cnt + CNT_W'(1);
                    end
                end
                // Payload must not linger in the buffer after it has been written.
                WR:    data_buf <= '0;
                FETCH: begin
                    data_buf <= bus.ram_rdata;
                    cnt      <= '0;
                end
                TX_DATA: begin
                    if (tx_hs) begin
                        cnt <= last_byte ? '0 : cnt + CNT_W'(1);
                        if (last_byte) data_buf <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.s_ready   = s_ready;
    assign bus.m_valid   = m_valid;
    assign bus.m_data    = m_data;
    assign bus.ram_addr  = slot;
    assign bus.ram_wdata = data_buf;
    assign bus.ram_we    = (state == WR);
    assign bus.busy      = (state != IDLE);
    assign bus.err       = err_q;

endmodule

// File: tb/tb_vault_stream_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vault_stream_ctrl
//   Directed bench for vault_stream_ctrl with a behavioural vault RAM.
//   Expected RAM writes and outbound bytes are queued as commands are sent
//   and compared by a negedge monitor as the DUT produces them.
//   Honours VAULT_ACK_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_vault_stream_ctrl;

    localparam int DATA_W = 256;
    localparam int ADDR_W = 4;
    localparam int NB     = DATA_W / 8;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } we_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vault_stream_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    vault_stream_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural vault RAM: combinational read, write on clock edge.
    logic [DATA_W-1:0] ram [2**ADDR_W];
    assign bus.ram_rdata = ram[bus.ram_addr];
    always @(posedge clk) if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q [$];
    we_t        exp_we_q [$];

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor state
    int         we_count    = 0;
    int         we_cyc      = 0;
    int         mv_rises    = 0;
    int         mv_rise_cyc = 0;
    logic       mv_prev     = 1'b0;
    logic       stalled     = 1'b0;
    logic [7:0] stall_data  = 8'h00;
    logic       rand_ready  = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            mv_prev = 1'b0;
            stalled = 1'b0;
        end else begin
            if (bus.ram_we) begin
                we_count++;
                we_cyc = cyc;
                check("we_pending", exp_we_q.size() != 0, 1);
                if (exp_we_q.size() != 0) begin
                    we_t e;
                    e = exp_we_q.pop_front();
                    check("we_addr", bus.ram_addr, e.addr);
                    check("we_data", bus.ram_wdata, e.data);
                end
            end
            if (bus.m_valid && !mv_prev) begin
                mv_rises++;
                mv_rise_cyc = cyc;
            end
            if (stalled) begin
                check("stall_valid", bus.m_valid, 1);
                check("stall_data", bus.m_data, stall_data);
            end
            if (bus.m_valid && bus.m_ready) begin
                check("mv_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("m_data", bus.m_data, exp_q.pop_front());
            end
            stalled    = bus.m_valid && !bus.m_ready;
            stall_data = bus.m_data;
            mv_prev    = bus.m_valid;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int acc_cyc = 0;

    task automatic send_byte(input logic [7:0] b);
        int n;
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (bus.s_ready) break;
            n++;
        end
        check("s_accept_timeout", n < 100, 1);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] s, input logic [DATA_W-1:0] d);
        we_t e;
        e.addr = s;
        e.data = d;
        exp_we_q.push_back(e);
`ifdef VAULT_ACK_EN
        exp_q.push_back({4'hA, s});
`endif
        send_byte({2'b01, 2'b00, s});
        for (int k = 0; k < NB; k++) send_byte(d[8*k +: 8]);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] s, input logic [DATA_W-1:0] d);
        for (int k = 0; k < NB; k++) exp_q.push_back(d[8*k +: 8]);
        send_byte({2'b10, 2'b00, s});
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || exp_we_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_drain"}, exp_q.size() + exp_we_q.size(), 0);
    endtask

    logic [DATA_W-1:0] pat_inc;
    logic [DATA_W-1:0] pat_rnd;
    int                we_before;
    int                rises_before;
    int                read_acc;

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) ram[i] = '0;
        for (int k = 0; k < NB; k++) pat_inc[8*k +: 8] = 8'(k);
        for (int k = 0; k < NB; k++) pat_rnd[8*k +: 8] = 8'($urandom_range(0, 255));
        bus.s_data  = 8'h00;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;

        // Reset state
        tick(2);
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_ram_we", bus.ram_we, 0);
        check("rst_err", bus.err, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_ram_wdata", bus.ram_wdata, 0);
        rst = 1'b0;
        #1;
        check("idle_s_ready", bus.s_ready, 1);

        // 1: write slot 3 with 0x00..0x1F
        we_before = we_count;
        do_write(4'd3, pat_inc);
        drain("t1", 20);
        check("t1_we_latency", we_cyc, acc_cyc + 1);
        check("t1_we_count", we_count - we_before, 1);
        check("t1_ram_slot3", ram[3], 256'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100);
        check("t1_busy", bus.busy, 0);

        // 2: read slot 3, m_ready held high
        do_read(4'd3, pat_inc);
        read_acc = acc_cyc;
        drain("t2", 200);
        check("t2_first_valid", mv_rise_cyc, read_acc + 2);
        tick();
        check("t2_busy", bus.busy, 0);

        // 3: read slot 3 with random back-pressure
        rand_ready = 1'b1;
        do_read(4'd3, pat_inc);
        drain("t3", 600);
        rand_ready = 1'b0;
        tick();
        bus.m_ready = 1'b1;
        tick();
        check("t3_busy", bus.busy, 0);

        // 4: illegal commands 0xC5 and 0x05
        we_before = we_count;
        send_byte(8'hC5);
        check("t4_err_c5", bus.err, 1);
        check("t4_idle_c5", bus.busy, 0);
        tick();
        check("t4_err_c5_clear", bus.err, 0);
        send_byte(8'h05);
        check("t4_err_05", bus.err, 1);
        check("t4_idle_05", bus.s_ready, 1);
        tick();
        check("t4_err_05_clear", bus.err, 0);
        check("t4_no_we", we_count, we_before);

        // 5: reset after 10 of 32 payload bytes, then write slot 15
        we_before = we_count;
        send_byte(8'h41);
        for (int k = 0; k < 10; k++) send_byte(8'hEE);
        rst = 1'b1;
        #1;
        check("t5_s_ready_rst", bus.s_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        check("t5_busy", bus.busy, 0);
        check("t5_m_valid", bus.m_valid, 0);
        tick(3);
        check("t5_no_we", we_count, we_before);
        do_write(4'd15, pat_rnd);
        drain("t5", 20);
        check("t5_ram_slot15", ram[15], pat_rnd);
        check("t5_ram_slot1", ram[1], 0);
        do_read(4'd15, pat_rnd);
        drain("t5_read", 200);

        // 6: acknowledge byte behaviour on a write to slot 7
        tick(2);
        rises_before = mv_rises;
        do_write(4'd7, ~pat_inc);
        drain("t6", 20);
        tick(2);
`ifdef VAULT_ACK_EN
        check("t6_ack_cycle", mv_rise_cyc, we_cyc + 1);
        check("t6_ack_count", mv_rises - rises_before, 1);
`else
        check("t6_no_m_valid", mv_rises, rises_before);
`endif
        check("t6_busy", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
